// File: rtl/placar_pkg.sv
// Shared scoreboard package: shot-clock controller state encoding and
// the default shot-counter constants used by the counter and display blocks.
package placar_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'b00,
    CORRENDO = 2'b01,
    VIOLACAO = 2'b10,
    REARME   = 2'b11
  } estado_t;

  localparam int SHOT_INIT_DEF = 14;
  localparam int CW_DEF        = 5;

endpackage

// File: rtl/controlador_posse_detector_borda.sv
// detector_borda: 1-bit rising-edge detector, synchronous active-low reset.
// Edge is combinational from the current input and the registered history.
module detector_borda (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sinal,
  output logic o_borda
);

  logic r_anterior;

  // Remember last cycle's level so a level already high never reads as an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_anterior <= 1'b0;
    end else begin
      r_anterior <= i_sinal;
    end
  end

  assign o_borda = i_sinal & ~r_anterior;

endmodule

// File: rtl/controlador_posse.sv
// controlador_posse: possession and shot-clock controller. Commands the
// 14-second shot counter (reset14 / chaveParar), detects violations from its
// buzzer, tracks possession and drives the operator horn.
// Optional feature: define REARME_TIMEOUT_EN to bound the rearm handshake to
// TIMEOUT cycles and raise the sticky erro_rearme flag when it expires.
module controlador_posse
  import placar_pkg::*;
#(
  parameter int SHOT_INIT  = SHOT_INIT_DEF,
  parameter int CW         = CW_DEF,
  parameter int BUZZ_TICKS = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          botao_iniciar,
  input  logic          botao_parar,
  input  logic          botao_posse,
  input  logic          botao_rebote,
  input  logic [CW-1:0] contagem_in,
  input  logic          buzzer_in,
  output logic          reset14,
  output logic          chaveParar,
  output logic          posse,
  output logic          violacao,
  output logic          buzzer_out,
  output logic [1:0]    estado,
  output logic          erro_rearme
);

  localparam int TKW = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS) : 1;

  if (BUZZ_TICKS < 1 || TIMEOUT < 1) begin : g_param_invalido
    $error("controlador_posse: BUZZ_TICKS and TIMEOUT must be at least 1");
  end

  estado_t          r_estado;
  estado_t          r_retorno;
  logic             r_reset14;
  logic             r_chave_parar;
  logic             r_posse;
  logic             r_violacao;
  logic             r_buzzer_out;
  logic [TKW-1:0]   r_tick_cnt;
  logic             w_borda_buzzer;
  logic             w_handshake;

  detector_borda u_borda_buzzer (
    .i_clk   (clock_in),
    .i_rst_n (reset_n),
    .i_sinal (buzzer_in),
    .o_borda (w_borda_buzzer)
  );

  // Counter has reloaded and its buzzer has cleared: rearm is complete.
  assign w_handshake = (contagem_in == CW'(SHOT_INIT)) && !buzzer_in;

`ifdef REARME_TIMEOUT_EN
  localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TOW-1:0] r_tout_cnt;
  logic           r_erro_rearme;
`endif

  // Controller FSM: state, return flag, tick/timeout counters and all outputs.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_estado      <= PARADO;
      r_retorno     <= PARADO;
      r_reset14     <= 1'b0;
      r_chave_parar <= 1'b1;
      r_posse       <= 1'b0;
      r_violacao    <= 1'b0;
      r_buzzer_out  <= 1'b0;
      r_tick_cnt    <= '0;
`ifdef REARME_TIMEOUT_EN
      r_tout_cnt    <= '0;
      r_erro_rearme <= 1'b0;
`endif
    end else begin
      r_violacao <= 1'b0;
      case (r_estado)
        PARADO: begin
          // A stop request while already stopped still outranks the others.
          if (!botao_parar) begin
            if (botao_posse) begin
              r_posse       <= ~r_posse;
              r_estado      <= REARME;
              r_retorno     <= PARADO;
              r_reset14     <= 1'b1;
              r_chave_parar <= 1'b1;
            end else if (botao_rebote) begin
              r_estado      <= REARME;
              r_retorno     <= PARADO;
              r_reset14     <= 1'b1;
              r_chave_parar <= 1'b1;
            end else if (botao_iniciar) begin
              r_estado      <= CORRENDO;
              r_chave_parar <= 1'b0;
            end
          end
        end

        CORRENDO: begin
          if (w_borda_buzzer) begin
            r_estado      <= VIOLACAO;
            r_violacao    <= 1'b1;
            r_posse       <= ~r_posse;
            r_buzzer_out  <= 1'b1;
            r_chave_parar <= 1'b1;
            r_tick_cnt    <= '0;
          end else if (botao_parar) begin
            r_estado      <= PARADO;
            r_chave_parar <= 1'b1;
          end else if (botao_posse) begin
            r_posse       <= ~r_posse;
            r_estado      <= REARME;
            r_retorno     <= CORRENDO;
            r_reset14     <= 1'b1;
            r_chave_parar <= 1'b1;
          end else if (botao_rebote) begin
            r_estado      <= REARME;
            r_retorno     <= CORRENDO;
            r_reset14     <= 1'b1;
            r_chave_parar <= 1'b1;
          end
        end

        VIOLACAO: begin
          // Horn lasts BUZZ_TICKS seconds, then rearm and come back stopped.
          if (tick) begin
            if (r_tick_cnt == TKW'(BUZZ_TICKS - 1)) begin
              r_tick_cnt   <= '0;
              r_buzzer_out <= 1'b0;
              r_estado     <= REARME;
              r_retorno    <= PARADO;
              r_reset14    <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        REARME: begin
          if (w_handshake) begin
            r_reset14     <= 1'b0;
            r_estado      <= r_retorno;
            r_chave_parar <= (r_retorno != CORRENDO);
`ifdef REARME_TIMEOUT_EN
            r_tout_cnt    <= '0;
          end else if (r_tout_cnt == TOW'(TIMEOUT - 1)) begin
            // Counter never acknowledged: give up and park stopped.
            r_tout_cnt    <= '0;
            r_reset14     <= 1'b0;
            r_erro_rearme <= 1'b1;
            r_estado      <= PARADO;
            r_chave_parar <= 1'b1;
          end else begin
            r_tout_cnt <= r_tout_cnt + 1'b1;
`endif
          end
        end

        default: begin
          r_estado <= PARADO;
        end
      endcase
    end
  end

  assign estado     = r_estado;
  assign reset14    = r_reset14;
  assign chaveParar = r_chave_parar;
  assign posse      = r_posse;
  assign violacao   = r_violacao;
  assign buzzer_out = r_buzzer_out;

`ifdef REARME_TIMEOUT_EN
  assign erro_rearme = r_erro_rearme;
`else
  assign erro_rearme = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_posse.sv
// Testbench for controlador_posse: directed test-plan steps followed by a
// randomized phase, all checked every cycle against a behavioural model.
module tb_controlador_posse;

  localparam int SHOT_INIT  = 14;
  localparam int CW         = 5;
  localparam int BUZZ_TICKS = 3;
  localparam int TIMEOUT    = 64;

  logic          clock_in = 1'b0;
  logic          reset_n;
  logic          tick;
  logic          botao_iniciar;
  logic          botao_parar;
  logic          botao_posse;
  logic          botao_rebote;
  logic [CW-1:0] contagem_in;
  logic          buzzer_in;
  logic          reset14;
  logic          chaveParar;
  logic          posse;
  logic          violacao;
  logic          buzzer_out;
  logic [1:0]    estado;
  logic          erro_rearme;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 stopped, 1 running, 2 horn, 3 waiting for reload.
  int m_state;
  int m_ret;
  int m_ticks;
  int m_wait;
  bit m_posse;
  bit m_prev;
  bit m_viol;
  bit m_err;

  controlador_posse #(
    .SHOT_INIT (SHOT_INIT),
    .CW        (CW),
    .BUZZ_TICKS(BUZZ_TICKS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .tick         (tick),
    .botao_iniciar(botao_iniciar),
    .botao_parar  (botao_parar),
    .botao_posse  (botao_posse),
    .botao_rebote (botao_rebote),
    .contagem_in  (contagem_in),
    .buzzer_in    (buzzer_in),
    .reset14      (reset14),
    .chaveParar   (chaveParar),
    .posse        (posse),
    .violacao     (violacao),
    .buzzer_out   (buzzer_out),
    .estado       (estado),
    .erro_rearme  (erro_rearme)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go_rearm(input int ret);
    m_state = 3;
    m_ret   = ret;
    m_wait  = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_update();
    bit rise;
    bit hs;
    if (!reset_n) begin
      m_state = 0; m_ret = 0; m_ticks = 0; m_wait = 0;
      m_posse = 0; m_prev = 0; m_viol = 0; m_err = 0;
      return;
    end
    rise   = buzzer_in && !m_prev;
    m_prev = buzzer_in;
    m_viol = 0;
    case (m_state)
      0: begin
        if (botao_parar) ;
        else if (botao_posse) begin m_posse = !m_posse; go_rearm(0); end
        else if (botao_rebote) go_rearm(0);
        else if (botao_iniciar) m_state = 1;
      end
      1: begin
        if (rise) begin
          m_state = 2; m_viol = 1; m_posse = !m_posse; m_ticks = 0;
        end
        else if (botao_parar) m_state = 0;
        else if (botao_posse) begin m_posse = !m_posse; go_rearm(1); end
        else if (botao_rebote) go_rearm(1);
      end
      2: begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == BUZZ_TICKS) go_rearm(0);
        end
      end
      default: begin
        hs = (int'(contagem_in) == SHOT_INIT) && !buzzer_in;
        if (hs) m_state = m_ret;
        else begin
          m_wait++;
`ifdef REARME_TIMEOUT_EN
          if (m_wait >= TIMEOUT) begin
            m_state = 0;
            m_err   = 1;
          end
`endif
        end
      end
    endcase
  endtask

  // One clock: update model, let the DUT take the edge, compare every output.
  task automatic step();
    model_update();
    @(posedge clock_in);
    #1;
    chk("estado",      {6'd0, estado},      8'(m_state));
    chk("chaveParar",  {7'd0, chaveParar},  {7'd0, (m_state != 1)});
    chk("reset14",     {7'd0, reset14},     {7'd0, (m_state == 3)});
    chk("buzzer_out",  {7'd0, buzzer_out},  {7'd0, (m_state == 2)});
    chk("posse",       {7'd0, posse},       {7'd0, m_posse});
    chk("violacao",    {7'd0, violacao},    {7'd0, m_viol});
    chk("erro_rearme", {7'd0, erro_rearme}, {7'd0, m_err});
  endtask

  task automatic clr_btns();
    botao_iniciar = 0; botao_parar = 0; botao_posse = 0; botao_rebote = 0; tick = 0;
  endtask

  initial begin
    int pick;
    reset_n = 0; buzzer_in = 0; contagem_in = 5'd14;
    clr_btns();
    m_state = 0; m_ret = 0; m_ticks = 0; m_wait = 0;
    m_posse = 0; m_prev = 0; m_viol = 0; m_err = 0;

    // Reset state
    step(); step();
    chk("rst_estado", {6'd0, estado}, 8'd0);
    chk("rst_chave", {7'd0, chaveParar}, 8'd1);

    // Reset then start
    reset_n = 1; step();
    botao_iniciar = 1; step(); clr_btns();
    chk("start_estado", {6'd0, estado}, 8'd1);
    chk("start_chave", {7'd0, chaveParar}, 8'd0);
    chk("start_posse", {7'd0, posse}, 8'd0);

    // Violation, horn for exactly BUZZ_TICKS ticks, rearm back to stopped
    contagem_in = 5'd5; step();
    buzzer_in = 1; step();
    chk("viol_pulse", {7'd0, violacao}, 8'd1);
    chk("viol_posse", {7'd0, posse}, 8'd1);
    step();
    chk("viol_pulse_end", {7'd0, violacao}, 8'd0);
    for (int i = 0; i < BUZZ_TICKS; i++) begin
      tick = 1; step(); tick = 0; step();
    end
    chk("horn_off", {7'd0, buzzer_out}, 8'd0);
    chk("rearm_req", {7'd0, reset14}, 8'd1);
    contagem_in = 5'd14; step(); step();
    chk("rearm_hold_buzz", {7'd0, reset14}, 8'd1);
    buzzer_in = 0; step();
    chk("rearm_done", {6'd0, estado}, 8'd0);

    // Possession while running
    botao_iniciar = 1; step(); clr_btns();
    contagem_in = 5'd7; botao_posse = 1; step(); clr_btns();
    chk("posse_r14", {7'd0, reset14}, 8'd1);
    step();
    contagem_in = 5'd14; step();
    chk("posse_ret", {6'd0, estado}, 8'd1);

    // Buzzer edge with possession button in the same cycle
    contagem_in = 5'd3; buzzer_in = 1; botao_posse = 1; step(); clr_btns();
    chk("simul_estado", {6'd0, estado}, 8'd2);
    chk("simul_posse", {7'd0, posse}, 8'd1);

    // Reset mid-horn after one tick
    tick = 1; step(); tick = 0;
    reset_n = 0; step();
    chk("rstmid_estado", {6'd0, estado}, 8'd0);
    chk("rstmid_horn", {7'd0, buzzer_out}, 8'd0);
    reset_n = 1;

    // Buzzer level already high when starting is not a violation
    botao_iniciar = 1; step(); clr_btns();
    step(); step();
    chk("level_high", {6'd0, estado}, 8'd1);
    buzzer_in = 0;

    // Stop and start together while running
    botao_parar = 1; botao_iniciar = 1; step(); clr_btns();
    chk("stop_start", {6'd0, estado}, 8'd0);

    // Stuck counter during rearm
    contagem_in = 5'd5; botao_rebote = 1; step(); clr_btns();
`ifdef REARME_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) step();
    chk("tout_err", {7'd0, erro_rearme}, 8'd1);
    chk("tout_r14", {7'd0, reset14}, 8'd0);
    chk("tout_estado", {6'd0, estado}, 8'd0);
    botao_iniciar = 1; step(); clr_btns();
    chk("tout_sticky", {7'd0, erro_rearme}, 8'd1);
`else
    for (int i = 0; i < TIMEOUT + 16; i++) step();
    chk("wait_estado", {6'd0, estado}, 8'd3);
    chk("wait_err", {7'd0, erro_rearme}, 8'd0);
    contagem_in = 5'd14; step();
    chk("wait_done", {6'd0, estado}, 8'd0);
`endif

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      reset_n       = ($urandom_range(0, 299) != 0);
      botao_iniciar = ($urandom_range(0, 7) == 0);
      botao_parar   = ($urandom_range(0, 15) == 0);
      botao_posse   = ($urandom_range(0, 15) == 0);
      botao_rebote  = ($urandom_range(0, 15) == 0);
      tick          = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) buzzer_in = !buzzer_in;
      pick = $urandom_range(0, 5);
      case (pick)
        0, 1: contagem_in = 5'd14;
        2:    contagem_in = 5'd7;
        3:    contagem_in = 5'd0;
        default: contagem_in = CW'($urandom_range(0, 31));
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
